// File: rtl/ppu_vram_arbiter_pkg.sv
// Shared PPU constants: requester indices and VRAM address-space layout.
package ppu_pkg;

    localparam int REQ_COLOR = 0;
    localparam int REQ_TILE  = 1;
    localparam int REQ_CPU   = 2;

    localparam logic [15:0] PPU_ADDR_MASK = 16'h3FFF;
    localparam logic [7:0]  PALETTE_PAGE  = 8'h3F;

endpackage

// File: rtl/ppu_vram_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after last_i, wrapping.
module ppu_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  pick_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand;

    always_comb begin
        pick_o  = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        // Walk outward from the last winner; the nearest eligible index wins.
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_i) + k) % N);
            if (!valid_o && eligible_i[cand]) begin
                valid_o      = 1'b1;
                idx_o        = cand;
                pick_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Round-robin arbiter for the single PPU VRAM port: registered issue, address
// mirroring, CPU blocking during rendering, and tagged read return.
module ppu_vram_arbiter
    import ppu_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int RD_LAT  = 1,
    parameter int CPU_IDX = REQ_CPU
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                render_active_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    req_we_i,
    input  logic [N_REQ*AW-1:0] req_addr_i,
    input  logic [N_REQ*DW-1:0] req_wdata_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    rvalid_o,
    output logic [DW-1:0]       rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_wdata_o,
    input  logic [DW-1:0]       mem_rdata_i,
    output logic                busy_o
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    function automatic logic [AW-1:0] mirror_addr(input logic [AW-1:0] addr);
        logic [AW-1:0] a;
        a = addr & AW'(PPU_ADDR_MASK);
        // Palette page repeats every 32 bytes; sprite colour 0 aliases background.
        if (a[13:8] == PALETTE_PAGE[5:0]) begin
            a = AW'({PALETTE_PAGE, 3'b000, a[4:0]});
            if (a[4] && (a[1:0] == 2'b00)) a[4] = 1'b0;
        end
        return a;
    endfunction

    logic [N_REQ-1:0]  cpu_block;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  pick;
    logic [IW-1:0]     pick_idx;
    logic              pick_vld;

    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DW-1:0]     mem_wdata_q, mem_wdata_d;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [IW-1:0]     tag_idx_q [RD_LAT];

    always_comb begin
        cpu_block          = '0;
        cpu_block[CPU_IDX] = render_active_i;
    end

    // Masking last cycle's grant stops a requester being issued twice for one request.
    assign eligible = req_i & ~gnt_q & ~cpu_block;

    ppu_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .eligible_i (eligible),
        .last_i     (ptr_q),
        .pick_o     (pick),
        .idx_o      (pick_idx),
        .valid_o    (pick_vld)
    );

    always_comb begin
        gnt_d       = pick;
        mem_en_d    = pick_vld;
        ptr_d       = ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (pick_vld) begin
            ptr_d       = pick_idx;
            mem_we_d    = req_we_i[pick_idx];
            mem_addr_d  = mirror_addr(req_addr_i[pick_idx*AW +: AW]);
            mem_wdata_d = req_wdata_i[pick_idx*DW +: DW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gnt_q       <= '0;
            ptr_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // ptr_q names the requester behind the access currently on the memory port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) tag_idx_q[k] <= '0;
        end else begin
            tag_vld_q[0] <= mem_en_q & ~mem_we_q;
            tag_idx_q[0] <= ptr_q;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (tag_vld_q[RD_LAT-1]) begin
            rvalid_o[tag_idx_q[RD_LAT-1]] = 1'b1;
            rdata_o                       = mem_rdata_i;
        end
    end

    assign gnt_o       = gnt_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (|req_i) | (|tag_vld_q) | mem_en_q;

endmodule
